// File: rtl/booth_mult.sv
// Sequential signed multiplier, radix-2 Booth recoding, one iteration per clock.
// Latency: WIDTH edges from the start edge to hi/lo valid with a one-cycle done pulse.
// No backpressure: start is accepted on any edge and aborts/reloads an operation in flight.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   a_add;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic             last_iter;

    // State register and all datapath flops; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next state: start always (re)enters RUN, the last iteration drops back to IDLE
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (state_q == RUN && cnt_q == CNT_ONE) begin
            state_d = IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == RUN);
    end

    // Booth step: add/subtract M per {Q[0], q_1}, then arithmetic shift of {A, Q, q_1}
    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   a_add = a_q + m_q;
            2'b10:   a_add = a_q - m_q;
            default: a_add = a_q;
        endcase
        a_sh      = {a_add[WIDTH], a_add[WIDTH:1]};
        q_sh      = {a_add[0], q_q[WIDTH-1:1]};
        last_iter = (state_q == RUN) && !start && (cnt_q == CNT_ONE);
    end

    // Datapath next values: load on start, iterate in RUN, publish result only on a clean completion
    always_comb begin
        cnt_d  = cnt_q;
        m_d    = m_q;
        a_d    = a_q;
        q_d    = q_q;
        q1_d   = q1_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (start) begin
            m_d   = {srcA[WIDTH-1], srcA};
            a_d   = '0;
            q_d   = srcB;
            q1_d  = 1'b0;
            cnt_d = CNT_INIT;
        end else if (state_q == RUN) begin
            a_d   = a_sh;
            q_d   = q_sh;
            q1_d  = q_q[0];
            cnt_d = cnt_q - CNT_ONE;
            if (last_iter) begin
                // the extra sign bit of A is redundant here and is dropped
                hi_d   = a_sh[WIDTH-1:0];
                lo_d   = q_sh;
                done_d = 1'b1;
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [63:0] exp_q[$];

    booth_mult #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Scoreboard: every done pulse consumes the oldest expected product
    always @(posedge clk) begin
        #1;
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                check("product", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Run one multiply to completion; caller is just after a clock edge
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int cycles;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        exp_q.push_back(exp);
        tick();
        start = 1'b0;
        srcA  = $urandom;
        srcB  = $urandom;
        cycles = 0;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
        check("busy_cycles", 64'(cycles), 64'd32);
        check("done_pulse", {63'd0, done}, 64'd1);
        tick();
        check("done_clear", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int cycles;
        int done_before;
        logic [31:0] ra, rb;
        logic        held_ok;

        reset = 1'b1;
        start = 1'b0;
        srcA  = '0;
        srcB  = '0;
        repeat (3) tick();
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed products with hand-computed results
        do_mult(32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        do_mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        do_mult(32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000);
        do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        do_mult(32'd0,         32'hDEAD_BEEF, 64'd0);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

        // Random products against the behavioural model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_mult(ra, rb, model(ra, rb));
        end

        // Restart: 5x6 aborted by 100x(-1) ten cycles later; 2x3 must hold meanwhile
        do_mult(32'd2, 32'd3, 64'd6);
        done_before = n_done;
        srcA  = 32'd5;
        srcB  = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        held_ok = 1'b1;
        repeat (9) begin
            if ({hi, lo} !== 64'd6) held_ok = 1'b0;
            tick();
        end
        srcA  = 32'd100;
        srcB  = 32'hFFFF_FFFF;
        start = 1'b1;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF9C);
        tick();
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            if ({hi, lo} !== 64'd6) held_ok = 1'b0;
            tick();
            cycles++;
        end
        check("restart_hold", {63'd0, held_ok}, 64'd1);
        check("restart_cycles", 64'(cycles), 64'd32);
        repeat (5) tick();
        check("restart_one_done", 64'(n_done - done_before), 64'd1);

        // Reset mid-run: operation dropped, outputs cleared, no done
        srcA  = 32'd12;
        srcB  = 32'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        done_before = n_done;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_run_busy", {63'd0, busy}, 64'd0);
        check("rst_run_hilo", {hi, lo}, 64'd0);
        repeat (40) tick();
        check("rst_run_no_done", 64'(n_done - done_before), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
